// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - ALSU command field layout, opcodes and illegal-command check
package alsu_pkg;

  // Packed command, MSB to LSB: A, B, opcode, cin, serial_in, red_op_A,
  // red_op_B, bypass_A, bypass_B, direction.
  localparam int CMD_W         = 16;
  localparam int FIELD_W       = 3;
  localparam int A_LSB         = 13;
  localparam int B_LSB         = 10;
  localparam int OP_LSB        = 7;
  localparam int CIN_BIT       = 6;
  localparam int SERIAL_IN_BIT = 5;
  localparam int RED_OP_A_BIT  = 4;
  localparam int RED_OP_B_BIT  = 3;
  localparam int BYPASS_A_BIT  = 2;
  localparam int BYPASS_B_BIT  = 1;
  localparam int DIRECTION_BIT = 0;

  localparam logic [7:0] ILLEGAL_CNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    OP_OR        = 3'd0,
    OP_XOR       = 3'd1,
    OP_ADD       = 3'd2,
    OP_MULT      = 3'd3,
    OP_SHIFT     = 3'd4,
    OP_ROTATE    = 3'd5,
    OP_INVALID_6 = 3'd6,
    OP_INVALID_7 = 3'd7
  } opcode_e;

  // Reduction modes are only meaningful for the bitwise OR/XOR opcodes.
  function automatic logic is_illegal(input logic [2:0] opcode,
                                      input logic       red_op_a,
                                      input logic       red_op_b);
    logic reserved;
    logic bad_reduce;
    reserved   = (opcode == 3'(OP_INVALID_6)) || (opcode == 3'(OP_INVALID_7));
    bad_reduce = (red_op_a | red_op_b) && (opcode > 3'(OP_XOR));
    return reserved || bad_reduce;
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// rtl/alsu_cmd_fifo.sv - DEPTH x 16 command FIFO with occupancy count and flush
module alsu_cmd_fifo
  import alsu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [CMD_W-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count; full blocks push even with a pop.
  always_comb begin
    push     = wr_en & ~full & ~flush;
    pop      = rd_en & ~empty & ~flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// rtl/alsu_cmd_sequencer.sv - buffers ALSU commands, drives ALSU pins, tracks results
module alsu_cmd_sequencer
  import alsu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ALSU_LAT = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             issue_en,
  input  logic             flush,
  output logic [2:0]       A,
  output logic [2:0]       B,
  output logic [2:0]       opcode,
  output logic             cin,
  output logic             serial_in,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  output logic             direction,
  output logic             issue_valid,
  output logic             issue_illegal,
  output logic             res_valid,
  output logic             res_illegal,
  output logic [CW-1:0]    fifo_count,
  output logic [7:0]       illegal_cnt
);

  logic [CMD_W-1:0]    head;
  logic                full, empty, pop;
  logic [CMD_W-1:0]    drive_q, drive_d;
  logic                issue_valid_q, issue_valid_d;
  logic                issue_illegal_q, issue_illegal_d;
  logic [7:0]          illegal_cnt_q, illegal_cnt_d;
  logic [ALSU_LAT-1:0] pv_q, pv_d;
  logic [ALSU_LAT-1:0] pi_q, pi_d;

  alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (flush),
    .wr_en   (cmd_valid),
    .wr_data (cmd_data),
    .rd_en   (issue_en),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign cmd_ready = ~full;
  assign pop       = issue_en & ~empty & ~flush;

  // Issue the head when allowed, otherwise drive an all-zero idle command.
  always_comb begin
    drive_d         = '0;
    issue_valid_d   = 1'b0;
    issue_illegal_d = 1'b0;
    if (pop) begin
      drive_d         = head;
      issue_valid_d   = 1'b1;
      issue_illegal_d = is_illegal(head[OP_LSB +: FIELD_W], head[RED_OP_A_BIT], head[RED_OP_B_BIT]);
    end
    illegal_cnt_d = illegal_cnt_q;
    if (issue_illegal_d && (illegal_cnt_q != ILLEGAL_CNT_MAX)) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  // Result tracking pipe, one stage per ALSU latency edge; flush drops in-flight work.
  always_comb begin
    pv_d[0] = issue_valid_q;
    pi_d[0] = issue_illegal_q;
    for (int i = 1; i < ALSU_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    if (flush) begin
      pv_d = '0;
      pi_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drive_q         <= '0;
      issue_valid_q   <= 1'b0;
      issue_illegal_q <= 1'b0;
      illegal_cnt_q   <= '0;
      pv_q            <= '0;
      pi_q            <= '0;
    end else begin
      drive_q         <= drive_d;
      issue_valid_q   <= issue_valid_d;
      issue_illegal_q <= issue_illegal_d;
      illegal_cnt_q   <= illegal_cnt_d;
      pv_q            <= pv_d;
      pi_q            <= pi_d;
    end
  end

  assign A             = drive_q[A_LSB +: FIELD_W];
  assign B             = drive_q[B_LSB +: FIELD_W];
  assign opcode        = drive_q[OP_LSB +: FIELD_W];
  assign cin           = drive_q[CIN_BIT];
  assign serial_in     = drive_q[SERIAL_IN_BIT];
  assign red_op_A      = drive_q[RED_OP_A_BIT];
  assign red_op_B      = drive_q[RED_OP_B_BIT];
  assign bypass_A      = drive_q[BYPASS_A_BIT];
  assign bypass_B      = drive_q[BYPASS_B_BIT];
  assign direction     = drive_q[DIRECTION_BIT];
  assign issue_valid   = issue_valid_q;
  assign issue_illegal = issue_illegal_q;
  assign res_valid     = pv_q[ALSU_LAT-1];
  assign res_illegal   = pi_q[ALSU_LAT-1];
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// tb/tb_alsu_cmd_sequencer.sv - directed self-checking bench for alsu_cmd_sequencer
module tb_alsu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic        issue_en;
  logic        flush;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic        issue_valid, issue_illegal, res_valid, res_illegal;
  logic [2:0]  fifo_count;
  logic [7:0]  illegal_cnt;

  int checks   = 0;
  int failures = 0;

  alsu_cmd_sequencer #(.DEPTH(4), .ALSU_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .issue_en      (issue_en),
    .flush         (flush),
    .A             (A),
    .B             (B),
    .opcode        (opcode),
    .cin           (cin),
    .serial_in     (serial_in),
    .red_op_A      (red_op_A),
    .red_op_B      (red_op_B),
    .bypass_A      (bypass_A),
    .bypass_B      (bypass_B),
    .direction     (direction),
    .issue_valid   (issue_valid),
    .issue_illegal (issue_illegal),
    .res_valid     (res_valid),
    .res_illegal   (res_illegal),
    .fifo_count    (fifo_count),
    .illegal_cnt   (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic [6:0] flags);
    return {a, b, op, flags};
  endfunction

  logic [15:0] q[$];
  logic [15:0] exp_word;
  logic [15:0] obs_word;
  int          mdl_cnt;
  int          n_issue;
  int          n_res;
  logic        acc, pp;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; issue_en = 1'b0; flush = 1'b0;
    #12;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
    chk("rst_A", 32'(A), 0);
    @(negedge clk); rst = 1'b1;
    step();
    chk("rel_cmd_ready", 32'(cmd_ready), 1);

    // Single command: A=2, B=2, opcode=ADD
    cmd_valid = 1'b1; cmd_data = 16'h4900; issue_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("single_cnt_after_push", 32'(fifo_count), 1);
    chk("single_not_yet_issued", 32'(issue_valid), 0);
    step();
    chk("single_issue_valid", 32'(issue_valid), 1);
    chk("single_A", 32'(A), 2);
    chk("single_B", 32'(B), 2);
    chk("single_opcode", 32'(opcode), 2);
    chk("single_legal", 32'(issue_illegal), 0);
    chk("single_res_early", 32'(res_valid), 0);
    step();
    chk("single_idle_valid", 32'(issue_valid), 0);
    chk("single_idle_A", 32'(A), 0);
    chk("single_res_k2", 32'(res_valid), 0);
    step();
    chk("single_res_k3", 32'(res_valid), 1);
    chk("single_res_illegal", 32'(res_illegal), 0);
    step();
    chk("single_res_k4", 32'(res_valid), 0);

    // Fill/full with issue paused: fifth push is refused
    issue_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = mk(3'(i + 1), 3'(i), 3'd2, 7'b0);
      step();
      if (i == 3) chk("full_ready_low", 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_no_issue", 32'(issue_valid), 0);
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_issue_valid", 32'(issue_valid), 1);
      chk("drain_A_order", 32'(A), 32'(i + 1));
      chk("drain_B_order", 32'(B), 32'(i));
      if (i == 0) chk("drain_ready_back", 32'(cmd_ready), 1);
    end
    step();
    chk("drain_done_valid", 32'(issue_valid), 0);
    chk("drain_done_A", 32'(A), 0);
    step(); step();

    // Illegal detection sequence
    cmd_valid = 1'b1; cmd_data = mk(3'd1, 3'd1, 3'd6, 7'b0000000);
    step();
    cmd_data = mk(3'd1, 3'd1, 3'd3, 7'b0010000);
    step();
    chk("ill_op6_issue", 32'(issue_illegal), 1);
    cmd_data = mk(3'd1, 3'd1, 3'd1, 7'b0001000);
    step();
    cmd_valid = 1'b0;
    chk("ill_op3_redA_issue", 32'(issue_illegal), 1);
    step();
    chk("ill_op1_redB_issue", 32'(issue_illegal), 0);
    chk("ill_op1_redB_valid", 32'(issue_valid), 1);
    chk("ill_res0_valid", 32'(res_valid), 1);
    chk("ill_res0_illegal", 32'(res_illegal), 1);
    step();
    chk("ill_res1_illegal", 32'(res_illegal), 1);
    step();
    chk("ill_res2_valid", 32'(res_valid), 1);
    chk("ill_res2_illegal", 32'(res_illegal), 0);
    chk("ill_cnt_2", 32'(illegal_cnt), 2);
    step();

    // 300 illegal commands saturate the counter
    cmd_valid = 1'b1; cmd_data = mk(3'd0, 3'd0, 3'd7, 7'b0);
    for (int i = 0; i < 300; i++) step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ill_cnt_sat", 32'(illegal_cnt), 255);

    // Flush with 3 queued and 2 in flight, plus a simultaneous push
    issue_en = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_data = mk(3'd4, 3'(i), 3'd0, 7'b0);
      step();
    end
    issue_en = 1'b1;
    cmd_data = mk(3'd4, 3'd3, 3'd0, 7'b0);
    step();
    cmd_data = mk(3'd4, 3'd4, 3'd0, 7'b0);
    step();
    chk("pre_flush_count", 32'(fifo_count), 3);
    chk("pre_flush_inflight", 32'(issue_valid), 1);
    flush = 1'b1; cmd_data = mk(3'd6, 3'd6, 3'd0, 7'b0);
    step();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("flush_count", 32'(fifo_count), 0);
    chk("flush_issue_valid", 32'(issue_valid), 0);
    chk("flush_A_idle", 32'(A), 0);
    n_res = 0; n_issue = 0;
    for (int i = 0; i < 5; i++) begin
      n_res   += int'(res_valid);
      n_issue += int'(issue_valid);
      step();
    end
    chk("flush_no_res", 32'(n_res), 0);
    chk("flush_push_dropped", 32'(n_issue), 0);

    // Random push/pop with wrap-around against a queue model
    q.delete(); mdl_cnt = 0; n_issue = 0; n_res = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_valid = 1'($urandom);
      issue_en  = 1'($urandom);
      cmd_data  = 16'($urandom);
      chk("rand_ready", 32'(cmd_ready), 32'(mdl_cnt != 4));
      acc = cmd_valid && (mdl_cnt != 4);
      pp  = issue_en && (mdl_cnt != 0);
      exp_word = '0;
      if (pp) exp_word = q.pop_front();
      if (acc) q.push_back(cmd_data);
      mdl_cnt = q.size();
      step();
      obs_word = {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
      chk("rand_issue_valid", 32'(issue_valid), 32'(pp));
      chk("rand_issue_word", 32'(obs_word), 32'(exp_word));
      chk("rand_count", 32'(fifo_count), 32'(mdl_cnt));
      n_issue += int'(pp);
      n_res   += int'(res_valid);
    end
    cmd_valid = 1'b0; issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pp = (q.size() != 0);
      exp_word = '0;
      if (pp) exp_word = q.pop_front();
      step();
      obs_word = {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
      chk("rand_drain_word", 32'(obs_word), 32'(exp_word));
      n_issue += int'(pp);
      n_res   += int'(res_valid);
    end
    chk("rand_res_count", 32'(n_res), 32'(n_issue));

    // Asynchronous reset mid-stream
    issue_en = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_data = mk(3'd7, 3'(i), 3'd6, 7'b1111111);
      step();
    end
    cmd_valid = 1'b0; issue_en = 1'b1;
    step();
    chk("mid_pre_valid", 32'(issue_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_A", 32'(A), 0);
    chk("mid_rst_flags", 32'({cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}), 0);
    chk("mid_rst_issue", 32'({issue_valid, issue_illegal}), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_cnt", 32'(illegal_cnt), 0);
    issue_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    step();
    chk("mid_rel_ready", 32'(cmd_ready), 1);
    chk("mid_rel_count", 32'(fifo_count), 0);
    n_res = 0;
    for (int i = 0; i < 4; i++) begin
      n_res += int'(res_valid);
      step();
    end
    chk("mid_rel_no_res", 32'(n_res), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
